// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
// Module      : player_mover
// Description : Grid-collision player pose stepper (rotate, step, slide on walls)
// Revision    : 1.0 - initial release
// ============================================================================
module player_mover #(
  parameter int SPEED       = 16,
  parameter int TURN        = 2,
  parameter int SPAWN_X     = 384,
  parameter int SPAWN_Y     = 384,
  parameter int SPAWN_ANGLE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        start,
  output logic        done,
  input  logic        key_fwd,
  input  logic        key_back,
  input  logic        key_left,
  input  logic        key_right,
  output logic [5:0]  grid_x,
  output logic [4:0]  grid_y,
  input  logic [2:0]  grid_out,
  output logic [13:0] pos_x,
  output logic [12:0] pos_y,
  output logic [7:0]  angle
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROTATE, S_CALC, S_READ_X, S_CHECK_X, S_READ_Y, S_CHECK_Y, S_DONE
  } state_t;

  state_t             r_state;
  logic               r_fwd, r_back, r_left, r_right;
  logic signed [14:0] r_cx;
  logic signed [13:0] r_cy;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [6:0] quarter_sin(input logic [6:0] k);
    logic [6:0] t;
    case (k)
      7'd0:  t = 7'd0;   7'd1:  t = 7'd3;   7'd2:  t = 7'd6;   7'd3:  t = 7'd9;   7'd4:  t = 7'd12;
      7'd5:  t = 7'd16;  7'd6:  t = 7'd19;  7'd7:  t = 7'd22;  7'd8:  t = 7'd25;  7'd9:  t = 7'd28;
      7'd10: t = 7'd31;  7'd11: t = 7'd34;  7'd12: t = 7'd37;  7'd13: t = 7'd40;  7'd14: t = 7'd43;
      7'd15: t = 7'd46;  7'd16: t = 7'd49;  7'd17: t = 7'd51;  7'd18: t = 7'd54;  7'd19: t = 7'd57;
      7'd20: t = 7'd60;  7'd21: t = 7'd63;  7'd22: t = 7'd65;  7'd23: t = 7'd68;  7'd24: t = 7'd71;
      7'd25: t = 7'd73;  7'd26: t = 7'd76;  7'd27: t = 7'd78;  7'd28: t = 7'd81;  7'd29: t = 7'd83;
      7'd30: t = 7'd85;  7'd31: t = 7'd88;  7'd32: t = 7'd90;  7'd33: t = 7'd92;  7'd34: t = 7'd94;
      7'd35: t = 7'd96;  7'd36: t = 7'd98;  7'd37: t = 7'd100; 7'd38: t = 7'd102; 7'd39: t = 7'd104;
      7'd40: t = 7'd106; 7'd41: t = 7'd107; 7'd42: t = 7'd109; 7'd43: t = 7'd111; 7'd44: t = 7'd112;
      7'd45: t = 7'd113; 7'd46: t = 7'd115; 7'd47: t = 7'd116; 7'd48: t = 7'd117; 7'd49: t = 7'd118;
      7'd50: t = 7'd120; 7'd51: t = 7'd121; 7'd52: t = 7'd122; 7'd53: t = 7'd122; 7'd54: t = 7'd123;
      7'd55: t = 7'd124; 7'd56: t = 7'd125; 7'd57: t = 7'd125; 7'd58: t = 7'd126; 7'd59: t = 7'd126;
      7'd60: t = 7'd126; 7'd61: t = 7'd127; 7'd62: t = 7'd127; 7'd63: t = 7'd127;
      default: t = 7'd127;
    endcase
    return t;
  endfunction

  // Full-circle sine folded onto the quarter table; cosine is sine advanced by 64.
  function automatic logic signed [7:0] sin_q(input logic [7:0] a);
    logic [6:0] mag;
    mag = a[6] ? quarter_sin(7'd64 - {1'b0, a[5:0]}) : quarter_sin({1'b0, a[5:0]});
    return a[7] ? 8'(-{1'b0, mag}) : {1'b0, mag};
  endfunction

  logic signed [7:0]  w_cos, w_sin;
  logic signed [31:0] w_dx, w_dy, w_step_x, w_step_y;
  logic signed [14:0] w_cx;
  logic signed [13:0] w_cy;
  logic [13:0]        w_next_x;

  always_comb begin
    w_cos    = sin_q(angle + 8'd64);
    w_sin    = sin_q(angle);
    w_dx     = (32'(w_cos) * SPEED) >>> 7;
    w_dy     = (32'(w_sin) * SPEED) >>> 7;
    w_step_x = 32'sd0;
    w_step_y = 32'sd0;
    if (r_fwd && !r_back) begin
      w_step_x = w_dx;
      w_step_y = w_dy;
    end else if (r_back && !r_fwd) begin
      w_step_x = -w_dx;
      w_step_y = -w_dy;
    end
    w_cx     = 15'($signed({1'b0, pos_x}) + w_step_x);
    w_cy     = 14'($signed({1'b0, pos_y}) + w_step_y);
    // Negative sign bit means the candidate left the map; the grid answer is then moot.
    w_next_x = (!r_cx[14] && grid_out == 3'd0) ? r_cx[13:0] : pos_x;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_fwd   <= 1'b0;
      r_back  <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_cx    <= '0;
      r_cy    <= '0;
      pos_x   <= '0;
      pos_y   <= '0;
      angle   <= '0;
      done    <= 1'b0;
      grid_x  <= '0;
      grid_y  <= '0;
    end else if (init) begin
      r_state <= S_IDLE;
      pos_x   <= 14'(SPAWN_X);
      pos_y   <= 13'(SPAWN_Y);
      angle   <= 8'(SPAWN_ANGLE);
      done    <= 1'b0;
      grid_x  <= '0;
      grid_y  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fwd   <= key_fwd;
            r_back  <= key_back;
            r_left  <= key_left;
            r_right <= key_right;
            r_state <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          if (r_left && !r_right)      angle <= angle - 8'(TURN);
          else if (r_right && !r_left) angle <= angle + 8'(TURN);
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_cx    <= w_cx;
          r_cy    <= w_cy;
          grid_x  <= w_cx[13:8];
          grid_y  <= pos_y[12:8];
          r_state <= S_READ_X;
        end
        S_READ_X: r_state <= S_CHECK_X;
        S_CHECK_X: begin
          // Y probe uses the already-resolved X so a blocked axis still lets the other slide.
          pos_x   <= w_next_x;
          grid_x  <= w_next_x[13:8];
          grid_y  <= r_cy[12:8];
          r_state <= S_READ_Y;
        end
        S_READ_Y: r_state <= S_CHECK_Y;
        S_CHECK_Y: begin
          if (!r_cy[13] && grid_out == 3'd0) pos_y <= r_cy[12:0];
          grid_x  <= '0;
          grid_y  <= '0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_mover
// Description : Directed vector bench for player_mover over four spawn setups
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_mover;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init  = 1'b0;
  logic        start_s [4];
  logic        kf [4], kb [4], kl [4], kr [4];
  logic        done_s [4];
  logic [5:0]  gx [4];
  logic [4:0]  gy [4];
  logic [2:0]  gout [4];
  logic [13:0] px [4];
  logic [12:0] py [4];
  logic [7:0]  ang [4];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Synchronous-read grid: only instance 1 has a wall, at cell (2,1).
  always @(posedge clock)
    for (int i = 0; i < 4; i++)
      gout[i] <= (i == 1 && gx[i] == 6'd2 && gy[i] == 5'd1) ? 3'd3 : 3'd0;

  player_mover u0 (
    .clock(clock), .reset(reset), .init(init), .start(start_s[0]), .done(done_s[0]),
    .key_fwd(kf[0]), .key_back(kb[0]), .key_left(kl[0]), .key_right(kr[0]),
    .grid_x(gx[0]), .grid_y(gy[0]), .grid_out(gout[0]),
    .pos_x(px[0]), .pos_y(py[0]), .angle(ang[0]));

  player_mover #(.SPAWN_X(505)) u1 (
    .clock(clock), .reset(reset), .init(init), .start(start_s[1]), .done(done_s[1]),
    .key_fwd(kf[1]), .key_back(kb[1]), .key_left(kl[1]), .key_right(kr[1]),
    .grid_x(gx[1]), .grid_y(gy[1]), .grid_out(gout[1]),
    .pos_x(px[1]), .pos_y(py[1]), .angle(ang[1]));

  player_mover #(.SPAWN_ANGLE(64)) u2 (
    .clock(clock), .reset(reset), .init(init), .start(start_s[2]), .done(done_s[2]),
    .key_fwd(kf[2]), .key_back(kb[2]), .key_left(kl[2]), .key_right(kr[2]),
    .grid_x(gx[2]), .grid_y(gy[2]), .grid_out(gout[2]),
    .pos_x(px[2]), .pos_y(py[2]), .angle(ang[2]));

  player_mover #(.SPAWN_X(5), .SPAWN_ANGLE(128)) u3 (
    .clock(clock), .reset(reset), .init(init), .start(start_s[3]), .done(done_s[3]),
    .key_fwd(kf[3]), .key_back(kb[3]), .key_left(kl[3]), .key_right(kr[3]),
    .grid_x(gx[3]), .grid_y(gy[3]), .grid_out(gout[3]),
    .pos_x(px[3]), .pos_y(py[3]), .angle(ang[3]));

  typedef struct {
    int   inst;
    logic f, b, l, r;
    int   ex_x, ex_y, ex_a;
    int   rx_gx, rx_gy, ry_gx, ry_gy;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic pulse_init();
    @(negedge clock);
    init = 1'b1;
    @(posedge clock);
    #1 init = 1'b0;
  endtask

  task automatic watch(input int i, input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clock);
      #1 if (done_s[i]) pulses++;
    end
  endtask

  // One full step; keys are inverted right after the capture edge to prove they are latched.
  task automatic run_vec(input int n, input vec_t v);
    int i, g3x, g3y, g5x, g5y;
    logic [7:0] dh;
    logic hold_ok, zero_ok;
    i = v.inst; dh = '0; hold_ok = 1'b1; zero_ok = 1'b1;
    g3x = 0; g3y = 0; g5x = 0; g5y = 0;
    @(negedge clock);
    start_s[i] = 1'b1; kf[i] = v.f; kb[i] = v.b; kl[i] = v.l; kr[i] = v.r;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) begin
        start_s[i] = 1'b0; kf[i] = ~v.f; kb[i] = ~v.b; kl[i] = ~v.l; kr[i] = ~v.r;
      end
      dh[k-1] = done_s[i];
      if ((k == 1 || k == 2 || k == 7 || k == 8) && (gx[i] != 6'd0 || gy[i] != 5'd0)) zero_ok = 1'b0;
      if (k == 3) begin g3x = int'(gx[i]); g3y = int'(gy[i]); end
      if (k == 4 && (int'(gx[i]) != g3x || int'(gy[i]) != g3y)) hold_ok = 1'b0;
      if (k == 5) begin g5x = int'(gx[i]); g5y = int'(gy[i]); end
      if (k == 6 && (int'(gx[i]) != g5x || int'(gy[i]) != g5y)) hold_ok = 1'b0;
    end
    kf[i] = 1'b0; kb[i] = 1'b0; kl[i] = 1'b0; kr[i] = 1'b0;
    chk($sformatf("v%0d done_seq", n), int'(dh), 8'h40);
    chk($sformatf("v%0d readx_gx", n), g3x, v.rx_gx);
    chk($sformatf("v%0d readx_gy", n), g3y, v.rx_gy);
    chk($sformatf("v%0d ready_gx", n), g5x, v.ry_gx);
    chk($sformatf("v%0d ready_gy", n), g5y, v.ry_gy);
    chk($sformatf("v%0d addr_hold", n), int'(hold_ok), 1);
    chk($sformatf("v%0d addr_idle_zero", n), int'(zero_ok), 1);
    chk($sformatf("v%0d pos_x", n), int'(px[i]), v.ex_x);
    chk($sformatf("v%0d pos_y", n), int'(py[i]), v.ex_y);
    chk($sformatf("v%0d angle", n), int'(ang[i]), v.ex_a);
  endtask

  initial begin
    int p, p2;
    //          inst  f     b     l     r     x    y    a    rxgx rxgy rygx rygy
    vt[0]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 399, 384, 0,   1,  1, 1, 1};
    vt[1]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 399, 384, 254, 1,  1, 1, 1};
    vt[2]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 399, 384, 254, 1,  1, 1, 1};
    vt[3]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 505, 384, 0,   2,  1, 1, 1};
    vt[4]  = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 384, 399, 64,  1,  1, 1, 1};
    vt[5]  = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 384, 384, 64,  1,  1, 1, 1};
    vt[6]  = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 5,   384, 128, 63, 1, 0, 1};
    vt[7]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 399, 384, 254, 1,  1, 1, 1};
    vt[8]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 399, 384, 0,   1,  1, 1, 1};
    vt[9]  = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 399, 384, 2,   1,  1, 1, 1};
    vt[10] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 414, 384, 2,   1,  1, 1, 1};
    vt[11] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 21,  384, 128, 0,  1, 0, 1};
    vt[12] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 505, 383, 254, 2,  1, 1, 1};

    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; kf[i] = 1'b0; kb[i] = 1'b0; kl[i] = 1'b0; kr[i] = 1'b0;
    end

    #2 reset = 1'b0;
    #1;
    chk("rst pos_x", int'(px[0]), 0);
    chk("rst pos_y", int'(py[0]), 0);
    chk("rst angle", int'(ang[0]), 0);
    chk("rst done", int'(done_s[0]), 0);
    chk("rst grid_x", int'(gx[0]), 0);
    chk("rst grid_y", int'(gy[0]), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    pulse_init();
    chk("init pos_x u1", int'(px[1]), 505);
    chk("init angle u3", int'(ang[3]), 128);

    for (int n = 0; n < 13; n++) run_vec(n, vt[n]);

    // A start raised while reading Y must not launch a second step.
    @(negedge clock);
    start_s[3] = 1'b1; kf[3] = 1'b1;
    @(posedge clock);
    #1 start_s[3] = 1'b0; kf[3] = 1'b0;
    p = 0;
    repeat (4) begin
      @(posedge clock);
      #1 if (done_s[3]) p++;
    end
    @(negedge clock);
    start_s[3] = 1'b1;
    @(posedge clock);
    #1 begin
      start_s[3] = 1'b0;
      if (done_s[3]) p++;
    end
    watch(3, 14, p2);
    chk("readY start pulses", p + p2, 1);
    chk("readY start pos_x", int'(px[3]), 5);

    // Init during a step aborts it silently.
    @(negedge clock);
    start_s[0] = 1'b1; kf[0] = 1'b1;
    @(posedge clock);
    #1 begin start_s[0] = 1'b0; kf[0] = 1'b0; end
    repeat (2) @(posedge clock);
    pulse_init();
    watch(0, 12, p);
    chk("init abort pulses", p, 0);
    chk("init abort pos_x", int'(px[0]), 384);
    chk("init abort grid_x", int'(gx[0]), 0);

    // Init wins over a simultaneous start.
    @(negedge clock);
    init = 1'b1; start_s[0] = 1'b1; kf[0] = 1'b1; kl[0] = 1'b1;
    @(posedge clock);
    #1 begin init = 1'b0; start_s[0] = 1'b0; kf[0] = 1'b0; kl[0] = 1'b0; end
    watch(0, 12, p);
    chk("init prio pulses", p, 0);
    chk("init prio angle", int'(ang[0]), 0);
    chk("init prio pos_x", int'(px[0]), 384);

    // Asynchronous reset landing in CHECK_X.
    @(negedge clock);
    start_s[0] = 1'b1; kf[0] = 1'b1;
    @(posedge clock);
    #1 begin start_s[0] = 1'b0; kf[0] = 1'b0; end
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("midstep rst pos_x", int'(px[0]), 0);
    chk("midstep rst pos_y", int'(py[0]), 0);
    chk("midstep rst angle", int'(ang[0]), 0);
    chk("midstep rst grid_x", int'(gx[0]), 0);
    chk("midstep rst grid_y", int'(gy[0]), 0);
    chk("midstep rst done", int'(done_s[0]), 0);
    @(negedge clock);
    reset = 1'b1;
    watch(0, 12, p);
    chk("post rst pulses", p, 0);
    chk("post rst pos_x", int'(px[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter SPEED, default 16: forward/back step magnitude scale (position units).
REQ-002 Parameter TURN, default 2: angle change per step (1/256 turn units).
REQ-003 Parameters SPAWN_X, SPAWN_Y, SPAWN_ANGLE, defaults 384, 384, 0: pose loaded by init.
REQ-004 clock  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 init  in  1  load spawn pose.
REQ-007 start  in  1  begin one movement step.
REQ-008 done  out  1  one-cycle step-complete pulse.
REQ-009 key_fwd, key_back, key_left, key_right  in  1 each  movement requests.
REQ-010 grid_x  out  6, grid_y  out  5  grid cell read address.
REQ-011 grid_out  in  3  cell contents; 0 = empty, nonzero = wall.
REQ-012 pos_x  out  14, pos_y  out  13, angle  out  8  player pose; cell = pos_x[13:8], pos_y[12:8].

Function
REQ-013 States IDLE, ROTATE, CALC, READ_X, CHECK_X, READ_Y, CHECK_Y, DONE; each non-IDLE state lasts exactly one cycle, in that order, DONE -> IDLE.
REQ-014 IDLE with start=1 -> ROTATE; the four keys are captured on that edge; key changes afterwards are ignored for the step.
REQ-015 start outside IDLE is ignored.
REQ-016 done = 1 only in DONE; it rises on the 7th rising edge counting the start-sampling edge as the 1st. Latency is fixed whether or not anything moves.
REQ-017 ROTATE: left only -> angle - TURN; right only -> angle + TURN; both or neither -> unchanged; modulo 256.
REQ-018 CALC uses the updated angle.
  - cos_q(a) = round(127*cos(2*pi*a/256)); sin_q(a) = round(127*sin(2*pi*a/256)); signed 8-bit, from an internal table.
  - dx = (cos_q*SPEED) >>> 7 and dy = (sin_q*SPEED) >>> 7, arithmetic (floor) shifts.
  - fwd only -> (+dx,+dy); back only -> (-dx,-dy); both or neither -> (0,0).
REQ-019 Candidates cx = pos_x + dx and cy = pos_y + dy are computed at 15 and 14 bits signed.
  - A candidate outside 0..16383 (x) or 0..8191 (y) is rejected without consulting the grid.
REQ-020 READ_X drives grid_x = cx[13:8], grid_y = pos_y[12:8] and holds them through CHECK_X.
  - grid_out is sampled in CHECK_X (one-cycle synchronous read).
  - pos_x <= cx iff in range and grid_out == 0.
REQ-021 READ_Y drives grid_x = pos_x[13:8] (already updated), grid_y = cy[12:8] and holds them through CHECK_Y.
  - pos_y <= cy iff in range and grid_out == 0.
  - The X and Y axes are accepted independently, giving wall sliding.
REQ-022 With zero delta, the grid reads still occur and the position is unchanged.
REQ-023 grid_x and grid_y are 0 in IDLE, ROTATE, CALC and DONE.
REQ-024 The block never writes the grid.
REQ-025 init = 1 (sampled at a rising edge, any state):
  - loads SPAWN_X, SPAWN_Y, SPAWN_ANGLE and forces IDLE;
  - aborts any step in progress with no done pulse;
  - has priority over start.
REQ-026 pos_x, pos_y and angle change only in ROTATE, CHECK_X, CHECK_Y, or on init.

Reset
REQ-027 reset = 0 forces, immediately and regardless of clock: state IDLE, pos_x 0, pos_y 0, angle 0, done 0, grid_x 0, grid_y 0.
REQ-028 Reset asserted mid-step aborts the step; no done pulse follows deassertion.
REQ-029 After reset deassertion the block idles until init or start.

Verification
REQ-030 Reset low during CHECK_X -> all outputs 0 asynchronously; after release with no start, done stays 0.
REQ-031 init, then start with key_fwd on an all-empty grid -> pos_x 399, pos_y 384, angle 0; done high one cycle at edge 7.
REQ-032 SPAWN_X=505, grid cell (2,1)=3, start with key_fwd -> grid_x=2, grid_y=1 in READ_X; pos_x stays 505, pos_y 384; done still at edge 7.
REQ-033 After init, start with key_left -> angle 254.
  - Next start with key_left and key_right together -> angle stays 254, position unchanged.
REQ-034 SPAWN_ANGLE=64: start with key_fwd -> pos_y 399, pos_x 384.
  - Then start with key_back -> pos_y 384.
REQ-035 SPAWN_X=5, SPAWN_ANGLE=128: start with key_fwd -> dx = -16, pos_x stays 5 (underflow rejected).
  - A start pulse re-asserted during READ_Y is ignored (exactly one done pulse).
